// File: rtl/phy_pkg.sv
// ============================================================================
//  Module   : phy_pkg
//  Purpose  : Shared constants and state encoding for the phy lane datapath.
//             The symbol constants are common to the transmit serializer and
//             the receive deserializer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package phy_pkg;

    // Alignment / comma symbol (K28.5)
    localparam logic [7:0] COM_BYTE = 8'hBC;
    // Idle symbol sent when the lane carries no valid data
    localparam logic [7:0] IDL_BYTE = 8'h7C;

    // Receive alignment state machine encoding
    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } rx_state_t;

endpackage : phy_pkg

`default_nettype wire

// File: rtl/phy_rx_deser.sv
// ============================================================================
//  Module   : phy_rx_deser
//  Purpose  : Single-lane serial receiver. Shifts one bit per clk_8f edge,
//             MSB first, locks byte alignment on a run of COM symbols and then
//             delivers recovered data bytes with a valid flag.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module phy_rx_deser
    import phy_pkg::*;
#(
    parameter int COM_LOCK = 4      // consecutive aligned COMs needed to lock (1..15)
) (
    input  logic       clk_8f,
    input  logic       reset,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       byte_strobe,
    output logic       active
);

    localparam logic [3:0] c_COM_LOCK = 4'(COM_LOCK);

    rx_state_t   r_state;
    logic [7:0]  r_shift;
    logic [2:0]  r_bit_cnt;
    logic [3:0]  r_com_cnt;
    logic [7:0]  r_data;
    logic        r_valid;
    logic        r_strobe;
    logic        r_active;

    rx_state_t   w_state_nxt;
    logic [7:0]  w_next_byte;
    logic        w_boundary;
    logic        w_is_com;
    logic        w_is_idl;
    logic [3:0]  w_com_inc;
    logic [2:0]  w_bit_cnt_nxt;
    logic [3:0]  w_com_cnt_nxt;
    logic [7:0]  w_data_nxt;
    logic        w_valid_nxt;
    logic        w_strobe_nxt;
    logic        w_active_nxt;

    // Register all state; reset discards any partial byte or partial lock
    always_ff @(posedge clk_8f or posedge reset) begin
        if (reset) begin
            r_state   <= SEARCH;
            r_shift   <= 8'h00;
            r_bit_cnt <= 3'd0;
            r_com_cnt <= 4'd0;
            r_data    <= 8'h00;
            r_valid   <= 1'b0;
            r_strobe  <= 1'b0;
            r_active  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_next_byte;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_com_cnt <= w_com_cnt_nxt;
            r_data    <= w_data_nxt;
            r_valid   <= w_valid_nxt;
            r_strobe  <= w_strobe_nxt;
            r_active  <= w_active_nxt;
        end
    end

    // Next-state and next-output logic for the alignment state machine
    always_comb begin
        w_next_byte   = {r_shift[6:0], serial_in};
        w_boundary    = (r_bit_cnt == 3'd7);
        w_is_com      = (w_next_byte == COM_BYTE);
        w_is_idl      = (w_next_byte == IDL_BYTE);
        w_com_inc     = r_com_cnt + 4'd1;

        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
        w_com_cnt_nxt = r_com_cnt;
        w_data_nxt    = r_data;
        w_valid_nxt   = r_valid;
        w_strobe_nxt  = 1'b0;
        w_active_nxt  = r_active;

        case (r_state)
            SEARCH: begin
                // Bit-granular slide: any window matching COM defines alignment
                if (w_is_com) begin
                    w_bit_cnt_nxt = 3'd0;
                    w_com_cnt_nxt = 4'd1;
                    if (c_COM_LOCK == 4'd1) begin
                        w_state_nxt  = ACTIVE;
                        w_active_nxt = 1'b1;
                    end else begin
                        w_state_nxt  = ALIGN;
                    end
                end
            end
            ALIGN: begin
                // Only aligned boundaries count; any other byte breaks the run
                if (w_boundary) begin
                    if (w_is_com) begin
                        w_com_cnt_nxt = w_com_inc;
                        if (w_com_inc == c_COM_LOCK) begin
                            w_state_nxt  = ACTIVE;
                            w_active_nxt = 1'b1;
                        end
                    end else begin
                        w_com_cnt_nxt = 4'd0;
                        w_state_nxt   = SEARCH;
                    end
                end
            end
            ACTIVE: begin
                // Sticky until reset; COM/IDL bytes drop valid but keep data
                if (w_boundary) begin
                    w_strobe_nxt = 1'b1;
                    if (w_is_com || w_is_idl) begin
                        w_valid_nxt = 1'b0;
                    end else begin
                        w_data_nxt  = w_next_byte;
                        w_valid_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = SEARCH;
            end
        endcase
    end

    assign data_out    = r_data;
    assign valid_out   = r_valid;
    assign byte_strobe = r_strobe;
    assign active      = r_active;

endmodule : phy_rx_deser

`default_nettype wire

// File: tb/tb_phy_rx_deser.sv
// ============================================================================
//  Module   : tb_phy_rx_deser
//  Purpose  : Directed self-checking bench for phy_rx_deser.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_phy_rx_deser;

    logic       clk_8f;
    logic       reset;
    logic       serial_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       byte_strobe;
    logic       active;

    int n_pass;
    int n_total;
    int n_strobe;

    phy_rx_deser #(.COM_LOCK(4)) u_dut (
        .clk_8f      (clk_8f),
        .reset       (reset),
        .serial_in   (serial_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .byte_strobe (byte_strobe),
        .active      (active)
    );

    initial clk_8f = 1'b0;
    always #5 clk_8f = ~clk_8f;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one bit and step past the edge that samples it
    task automatic send_bit(input logic b);
        serial_in = b;
        @(posedge clk_8f);
        #1;
        if (byte_strobe) n_strobe++;
    endtask

    // Drive one byte MSB first; n_strobe counts strobe pulses seen in it
    task automatic send_byte(input logic [7:0] b);
        n_strobe = 0;
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i]);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        serial_in = 1'b0;
        repeat (2) @(posedge clk_8f);
        #1;
        reset = 1'b0;
    endtask

    logic [7:0] mix_in    [4];
    logic [7:0] mix_data  [4];
    logic       mix_valid [4];

    initial begin
        n_pass    = 0;
        n_total   = 0;
        n_strobe  = 0;
        reset     = 1'b1;
        serial_in = 1'b0;

        mix_in    = '{8'hA1, 8'h7C, 8'hBC, 8'hFF};
        mix_data  = '{8'hA1, 8'hA1, 8'hA1, 8'hFF};
        mix_valid = '{1'b1, 1'b0, 1'b0, 1'b1};

        // ---- Reset held for 5 cycles with bits toggling, then released mid-stream
        repeat (5) begin
            @(posedge clk_8f);
            #1;
            serial_in = ~serial_in;
        end
        check_val("rst_data",   data_out,    8'h00);
        check_val("rst_valid",  valid_out,   1'b0);
        check_val("rst_active", active,      1'b0);
        check_val("rst_strobe", byte_strobe, 1'b0);
        reset = 1'b0;
        send_byte(8'h55);
        check_val("post_rst_active", active,    1'b0);
        check_val("post_rst_valid",  valid_out, 1'b0);

        // ---- Lock on four aligned COMs, then first data byte
        do_reset();
        for (int k = 0; k < 4; k++) begin
            send_byte(8'hBC);
            check_val("lock_active", active, (k == 3) ? 32'd1 : 32'd0);
        end
        check_val("lock_valid",  valid_out,   1'b0);
        check_val("lock_strobe", byte_strobe, 1'b0);
        send_byte(8'h05);
        check_val("d05_data",    data_out,    8'h05);
        check_val("d05_valid",   valid_out,   1'b1);
        check_val("d05_strobe",  byte_strobe, 1'b1);
        check_val("d05_npulse",  n_strobe,    1);

        // ---- Idle/data mix
        for (int k = 0; k < 4; k++) begin
            send_byte(mix_in[k]);
            check_val("mix_data",   data_out,  mix_data[k]);
            check_val("mix_valid",  valid_out, mix_valid[k]);
            check_val("mix_npulse", n_strobe,  1);
        end

        // ---- Comma pattern spanning two data bytes must not realign
        send_byte(8'h5E);
        check_val("emb_5e_data",  data_out,  8'h5E);
        check_val("emb_5e_valid", valid_out, 1'b1);
        send_byte(8'hF0);
        check_val("emb_f0_data",  data_out,  8'hF0);
        check_val("emb_f0_valid", valid_out, 1'b1);
        check_val("emb_npulse",   n_strobe,  1);

        // ---- Asynchronous reset while active, checked before the next edge
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        reset = 1'b1;
        #1;
        check_val("arst_active", active,    1'b0);
        check_val("arst_data",   data_out,  8'h00);
        check_val("arst_valid",  valid_out, 1'b0);
        @(posedge clk_8f);
        #1;
        reset = 1'b0;

        // ---- Lock with a 3-bit offset in front of the COM run
        do_reset();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        for (int k = 0; k < 4; k++) begin
            send_byte(8'hBC);
        end
        check_val("ofs_active", active, 1'b1);
        send_byte(8'h5A);
        check_val("ofs_5a_data",  data_out,  8'h5A);
        check_val("ofs_5a_valid", valid_out, 1'b1);
        send_byte(8'hC3);
        check_val("ofs_c3_data",  data_out,  8'hC3);
        check_val("ofs_npulse",   n_strobe,  1);

        // ---- Broken lock: non-COM in ALIGN restarts the search
        do_reset();
        send_byte(8'hBC);
        send_byte(8'hBC);
        send_byte(8'h3A);
        check_val("brk_3a_active", active, 1'b0);
        for (int k = 0; k < 4; k++) begin
            send_byte(8'hBC);
            check_val("brk_run_active", active, (k == 3) ? 32'd1 : 32'd0);
        end
        send_byte(8'h11);
        check_val("brk_11_data",  data_out,  8'h11);
        check_val("brk_11_valid", valid_out, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_phy_rx_deser

`default_nettype wire
